// File: rtl/io_pin_arbiter.sv
// Round-robin arbiter letting two requesters serialise a byte onto one shared bidirectional pin.
// Define IOARB_RX_CAPTURE_EN to add a response-capture phase (RX) after bus turnaround.
//
// state | meaning
// IDLE  | pin released, waiting for a request
// DRIVE | granted byte driven LSB first, BIT_DIV cycles per bit
// TURN  | pin released for TURN cycles of bus turnaround
// RX    | pin released, response byte sampled (IOARB_RX_CAPTURE_EN only)

module io_pin_arbiter #(
    parameter int BIT_DIV = 4,
    parameter int TURN    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic       pin_o,
    output logic       pin_t,
`ifdef IOARB_RX_CAPTURE_EN
    input  logic       pin_i,
    output logic [7:0] rx_data,
    output logic       rx_valid
`else
    input  logic       pin_i
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;
`ifdef IOARB_RX_CAPTURE_EN
    localparam logic [1:0] S_RX    = 2'd3;
    localparam logic [7:0] RX_SAMPLE = 8'(BIT_DIV - 1 - BIT_DIV / 2);
`endif
    localparam logic [7:0] BIT_LOAD  = 8'(BIT_DIV - 1);
    localparam logic [7:0] TURN_LOAD = 8'(TURN - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       last_q, last_d;
    logic       arm_q, arm_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic       pin_o_q, pin_o_d;
    logic       pin_t_q, pin_t_d;
    logic       sync1_q, sync2_q;
    logic       win;
`ifdef IOARB_RX_CAPTURE_EN
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
`else
    logic       unused_pin_sync;
    assign unused_pin_sync = sync2_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        arm_d   = 1'b1;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        win     = 1'b0;
`ifdef IOARB_RX_CAPTURE_EN
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // arm_q blocks a grant on the first edge after reset release
                if (arm_q && req != 2'b00) begin
                    win     = (req == 2'b11) ? ~last_q : req[1];
                    state_d = S_DRIVE;
                    data_d  = win ? tx_data1 : tx_data0;
                    last_d  = win;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    cnt_d   = BIT_LOAD;
                    idx_d   = 3'd0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == 8'd0) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_TURN;
                        cnt_d   = TURN_LOAD;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        cnt_d = BIT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_TURN: begin
                if (cnt_q == 8'd0) begin
`ifdef IOARB_RX_CAPTURE_EN
                    state_d = S_RX;
                    cnt_d   = BIT_LOAD;
                    idx_d   = 3'd0;
`else
                    state_d = S_IDLE;
                    done_d  = last_q ? 2'b10 : 2'b01;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`ifdef IOARB_RX_CAPTURE_EN
            S_RX: begin
                if (cnt_q == RX_SAMPLE) begin
                    rx_sh_d = {sync2_q, rx_sh_q[7:1]};
                end
                if (cnt_q == 8'd0) begin
                    if (idx_q == 3'd7) begin
                        state_d    = S_IDLE;
                        done_d     = last_q ? 2'b10 : 2'b01;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh_d;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        cnt_d = BIT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        pin_t_d = (state_d != S_DRIVE);
        pin_o_d = (state_d == S_DRIVE) && data_d[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            last_q  <= 1'b1;
            arm_q   <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            pin_o_q <= 1'b0;
            pin_t_q <= 1'b1;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
`ifdef IOARB_RX_CAPTURE_EN
            rx_sh_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            arm_q   <= arm_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            pin_o_q <= pin_o_d;
            pin_t_q <= pin_t_d;
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
`ifdef IOARB_RX_CAPTURE_EN
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = (state_q != S_IDLE);
    assign pin_o = pin_o_q;
    assign pin_t = pin_t_q;
`ifdef IOARB_RX_CAPTURE_EN
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`endif

endmodule

// File: doc/io_pin_arbiter.md
IO_PIN_ARBITER -- requirements
Module: io_pin_arbiter

Interface
REQ-001 Parameter BIT_DIV, default 4: clock cycles per serial bit; legal range 1..255.
REQ-002 Parameter TURN, default 2: bus-turnaround cycles with the pin released; legal range 1..255.
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  2  request from requester 0 and requester 1; level-sensitive.
REQ-006 tx_data0  input  8  byte from requester 0; sampled at grant.
REQ-007 tx_data1  input  8  byte from requester 1; sampled at grant.
REQ-008 gnt  output  2  one-hot; one-cycle pulse marking the accepted requester.
REQ-009 done  output  2  one-hot; one-cycle pulse when the granted transaction completes.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 pin_o  output  1  drive value to the IOBUF I input.
REQ-012 pin_t  output  1  tristate control to the IOBUF T input; 1 = released/input, 0 = driving.
REQ-013 pin_i  input  1  pin value from the IOBUF O output; asynchronous to clk.
REQ-014 rx_data  output  8  captured response byte; present only when IOARB_RX_CAPTURE_EN is defined.
REQ-015 rx_valid  output  1  one-cycle pulse with done; present only when IOARB_RX_CAPTURE_EN is defined.

Function
REQ-016 The FSM SHALL have the states IDLE, DRIVE and TURN, plus RX when the macro is defined.
- IDLE: pin_t=1, pin_o=0.
- If req!=0 at a rising edge: go to DRIVE; latch the winner's byte; assert gnt for the first DRIVE cycle.
REQ-017 Arbitration SHALL be round-robin.
- Single requester wins.
- Both requesting: the requester not served last wins.
- After reset, requester 0 wins the first tie.
REQ-018 DRIVE SHALL hold pin_t=0 and present the byte LSB first, each bit for exactly BIT_DIV cycles; DRIVE lasts 8*BIT_DIV cycles.
REQ-019 TURN SHALL hold pin_t=1 and pin_o=0 for exactly TURN cycles.
REQ-020 Without the macro, TURN SHALL go to IDLE.
- done[winner] pulses in the first IDLE cycle.
- A request sampled in that same cycle is granted; minimum gap between transactions is 1 IDLE cycle.
REQ-021 pin_i SHALL pass through a 2-flop synchronizer before any use.
REQ-022 gnt and done SHALL never have more than one bit set; gnt SHALL never be asserted outside the first DRIVE cycle.
REQ-023 A requester whose req stays high after done SHALL be treated as a new request.
REQ-024 Changes to req or tx_data during DRIVE, TURN or RX SHALL have no effect on the current transaction.
REQ-025 Bit-cycle and bit-index counters SHALL be sized to count BIT_DIV, TURN and 8 bits without overflow; TURN=1 and BIT_DIV=1 SHALL work.

Reset
REQ-026 While rst_n=0 every register SHALL clear asynchronously, giving these values:
- state=IDLE, pin_t=1, pin_o=0, gnt=0, done=0, busy=0;
- rx_data=0, rx_valid=0;
- round-robin pointer = requester 1 served last.
REQ-027 Reset asserted mid-transaction SHALL release the pin immediately (no clock needed) and SHALL NOT produce done.
REQ-028 The first grant after reset deassertion SHALL occur no earlier than the second rising edge with rst_n=1.

Configuration
REQ-029 Macro IOARB_RX_CAPTURE_EN defined: the response-capture path SHALL be compiled in, behaving as follows.
- TURN goes to RX; RX lasts 8*BIT_DIV cycles with pin_t=1.
- The synchronized pin is sampled at cycle floor(BIT_DIV/2) of each bit and shifted into rx_data LSB first.
- Leaving RX: go to IDLE; rx_valid pulses together with done; rx_data holds until the next capture completes.
REQ-030 Macro undefined: the RX state, rx_data and rx_valid SHALL not exist, and timing SHALL follow REQ-020.

Verification
REQ-031 req=01, tx_data0=0xA5, BIT_DIV=4, TURN=2 -> gnt=01 for 1 cycle; pin_t=0 for 32 cycles; pin_o shows 1,0,1,0,0,1,0,1, each for 4 cycles; pin_t=1 for 2 cycles; done=01 in the next cycle (macro off).
REQ-032 req=11 held continuously, data 0x0F/0xF0 -> grants alternate 01,10,01,...; each grant follows the prior done by exactly 1 cycle.
REQ-033 Macro on, pin_i driven with 0x3C LSB first during RX, aligned to bit windows -> rx_data=0x3C, rx_valid and done pulse together.
REQ-034 rst_n pulsed low at cycle 10 of DRIVE -> pin_t=1 with no clock edge; no done; next req=10 after release is granted, and a tie afterwards goes to 0.
REQ-035 tx_data0 changed and req toggled during DRIVE -> pin_o pattern unchanged from the latched byte; no extra gnt.
REQ-036 BIT_DIV=1, TURN=1, req=01, tx_data0=0x01 -> DRIVE lasts 8 cycles, pin_o=1 only in the first DRIVE cycle, TURN lasts 1 cycle.
